// File: rtl/shift_pkg.sv
// shift_pkg: shared ALU op and shift-FSM state encodings
package shift_pkg;
   typedef enum logic [1:0] {SHL = 2'b00, SHR = 2'b01, PASS = 2'b10, SRA = 2'b11} aluop_t;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} shst_t;
endpackage

// File: rtl/shift_stage.sv
// shift_stage: one log-stage, shifts data by 2^k when en is set
module shift_stage
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   localparam int SHAMT_W = $clog2(WIDTH)
) (
   input  aluop_t             op,
   input  logic [WIDTH-1:0]   data,
   input  logic [SHAMT_W-1:0] k,
   input  logic               en,
   output logic [WIDTH-1:0]   y
);
   logic [SHAMT_W:0] sh;
   logic signed [WIDTH-1:0] sra;
   assign sh = (SHAMT_W + 1)'(1) << k;
   assign sra = $signed(data) >>> sh;
   assign y = (!en || op == PASS) ? data :
              op == SHL ? data << sh :
              op == SRA ? sra : data >> sh;
endmodule

// File: rtl/shift_iter.sv
// shift_iter: handshaked multi-cycle shifter, one log-stage per clock
module shift_iter
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   localparam int SHAMT_W = $clog2(WIDTH)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [1:0]              ALUOp,
   input  logic signed [WIDTH-1:0] A,
   input  logic [SHAMT_W-1:0]      B,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic signed [WIDTH-1:0] shiftout
);
   localparam logic [SHAMT_W-1:0] k_last = SHAMT_W'(SHAMT_W - 1);
   shst_t state;
   aluop_t op;
   logic [WIDTH-1:0] work, nxt;
   logic [SHAMT_W-1:0] amt, k;
   shift_stage #(.WIDTH(WIDTH)) u_stage (.op(op), .data(work), .k(k), .en(amt[k]), .y(nxt));
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         op <= SHL;
         work <= '0;
         amt <= '0;
         k <= '0;
         req_ready <= 1'b0;
         resp_valid <= 1'b0;
         shiftout <= '0;
      end else begin
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  op <= aluop_t'(ALUOp);
                  work <= A;
                  amt <= B;
                  k <= '0;
                  req_ready <= 1'b0;
                  if (B == '0 || ALUOp == PASS) begin
                     state <= DONE;
                     resp_valid <= 1'b1;
                     shiftout <= A;
                  end else state <= SHIFT;
               end
            end
            SHIFT: begin
               work <= nxt;
               k <= k + 1'b1;
               if (k == k_last) begin
                  state <= DONE;
                  resp_valid <= 1'b1;
                  shiftout <= nxt;
               end
            end
            DONE: if (resp_ready) begin
               state <= IDLE;
               resp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
